// File: rtl/seq_fixed_point_div.sv
// Multi-cycle signed fixed-point divider for Q(WOI).(WOF) operands.
// Restoring shift-subtract, one quotient bit per cycle, valid/ready on both sides.
// The quotient carries one extra fraction bit so the result can be rounded
// half-up (away from zero) or truncated, then saturated like the converter.
module seq_fixed_point_div #(
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROUND = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WOI+WOF-1:0]   in_a,
    input  logic [WOI+WOF-1:0]   in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 overflow
);

    localparam int W    = WOI + WOF;
    localparam int QW   = W + WOF + 1;
    localparam int CW   = $clog2(QW);
    localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);
    localparam logic [QW:0]   RND_INC   = (ROUND != 0) ? (QW+1)'(1) : '0;

    typedef enum logic [1:0] {IDLE, DIV, FIX, DONE} state_t;

    state_t          state_q, state_d;
    logic            sign_q, sign_d;
    logic            dbz_q, dbz_d;
    logic [W-1:0]    b_mag_q, b_mag_d;
    logic [W:0]      rem_q, rem_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    out_q, out_d;
    logic            ovf_q, ovf_d;

    logic [W-1:0]    a_mag;
    logic [W-1:0]    b_mag;
    logic            b_zero;
    logic [W+1:0]    trial;
    logic            trial_ge;
    logic [QW:0]     qf_ext;
    logic [QW:0]     m_full;
    logic            mag_big;
    logic [W-1:0]    sat_val;

    // Operand magnitudes, restoring step and rounding/saturation datapath
    always_comb begin
        a_mag    = in_a[W-1] ? (~in_a + 1'b1) : in_a;
        b_mag    = in_b[W-1] ? (~in_b + 1'b1) : in_b;
        b_zero   = (in_b == '0);
        trial    = {rem_q, quo_q[QW-1]};
        trial_ge = (trial >= {2'b00, b_mag_q});
        qf_ext   = {1'b0, quo_q} + RND_INC;
        m_full   = qf_ext >> 1;
        mag_big  = |m_full[QW:W-1];
        sat_val  = sign_q ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end

    // Next-state and datapath updates for the IDLE/DIV/FIX/DONE sequence
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        dbz_d   = dbz_q;
        b_mag_d = b_mag_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = b_zero ? in_a[W-1] : (in_a[W-1] ^ in_b[W-1]);
                    dbz_d   = b_zero;
                    b_mag_d = b_mag;
                    rem_d   = '0;
                    quo_d   = {a_mag, {(WOF+1){1'b0}}};
                    cnt_d   = '0;
                    state_d = b_zero ? FIX : DIV;
                end
            end
            DIV: begin
                rem_d = trial_ge ? (W+1)'(trial - {2'b00, b_mag_q}) : (W+1)'(trial);
                quo_d = {quo_q[QW-2:0], trial_ge};
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            FIX: begin
                ovf_d = dbz_q | mag_big;
                if (dbz_q || mag_big) begin
                    out_d = sat_val;
                end else begin
                    out_d = sign_q ? (~m_full[W-1:0] + 1'b1) : m_full[W-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any division in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            dbz_q   <= 1'b0;
            b_mag_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            dbz_q   <= dbz_d;
            b_mag_q <= b_mag_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode the registered state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        out       = out_q;
        overflow  = ovf_q;
    end

endmodule

// File: tb/tb_seq_fixed_point_div.sv
// Self-checking bench for seq_fixed_point_div (WOI=8, WOF=8).
// A rounding instance and a truncating instance run in lockstep on shared inputs.
module tb_seq_fixed_point_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out;
    logic        overflow;
    logic        t_in_ready;
    logic        t_out_valid;
    logic [15:0] t_out;
    logic        t_overflow;

    int n_compared = 0;
    int n_failed   = 0;
    logic [16:0] sb[$];

    seq_fixed_point_div #(.WOI(8), .WOF(8), .ROUND(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .overflow(overflow)
    );

    seq_fixed_point_div #(.WOI(8), .WOF(8), .ROUND(0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_a(in_a), .in_b(in_b), .out_valid(t_out_valid), .out_ready(out_ready),
        .out(t_out), .overflow(t_overflow)
    );

    always #5 clk = ~clk;

    // Reference: {overflow, out} for rounding mode computed from real magnitudes
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b);
        longint am, bm, qf, m;
        logic neg;
        logic [15:0] r;
        if (b == 16'h0000) return {1'b1, a[15] ? 16'h8000 : 16'h7FFF};
        am  = a[15] ? 65536 - longint'(a) : longint'(a);
        bm  = b[15] ? 65536 - longint'(b) : longint'(b);
        qf  = (am * 512) / bm;
        m   = (qf + 1) / 2;
        neg = a[15] ^ b[15];
        if (m >= 32768) return {1'b1, neg ? 16'h8000 : 16'h7FFF};
        if (neg) m = -m;
        r = m[15:0];
        return {1'b0, r};
    endfunction

    task automatic drive_op(input logic [15:0] a, input logic [15:0] b,
                            input logic [16:0] exp, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) return;
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(output int cycles, output bit ready_seen);
        cycles     = 0;
        ready_seen = 1'b0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (in_ready) ready_seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_compared++;
        if (out_valid !== 1'b0) begin n_failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_compared++;
        if ({in_ready, t_in_ready} !== 2'b11) begin n_failed++; $display("FAIL reset_in_ready: got %b expected 11", {in_ready, t_in_ready}); end
        n_compared++;
        if (out !== 16'h0000) begin n_failed++; $display("FAIL reset_out: got %h expected 0000", out); end
        n_compared++;
        if (overflow !== 1'b0) begin n_failed++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok, rdy;
        int lat;
        logic [16:0] exp;
        drive_op(16'h0300, 16'h0200, {1'b0, 16'h0180}, ok);
        wait_result(lat, rdy);
        n_compared++;
        if (!ok || lat != 26) begin n_failed++; $display("FAIL basic_latency: got %0d (accepted %b) expected 26", lat, ok); end
        n_compared++;
        if (rdy !== 1'b0) begin n_failed++; $display("FAIL basic_in_ready_busy: got %b expected 0", rdy); end
        exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
        n_compared++;
        if ({overflow, out} !== exp) begin n_failed++; $display("FAIL basic_result: got %h expected %h", {overflow, out}, exp); end
        @(posedge clk); #1;
        n_compared++;
        if (in_ready !== 1'b1) begin n_failed++; $display("FAIL basic_return_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_rounding();
        bit ok, rdy;
        int lat;
        logic [16:0] exp;
        logic [15:0] va[3] = '{16'h0200, 16'hFD00, 16'hFD00};
        logic [15:0] vb[3] = '{16'h0300, 16'h0200, 16'hFE00};
        logic [15:0] vr[3] = '{16'h00AB, 16'hFE80, 16'h0180};
        for (int i = 0; i < 3; i++) begin
            drive_op(va[i], vb[i], {1'b0, vr[i]}, ok);
            wait_result(lat, rdy);
            exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
            n_compared++;
            if (!ok || {overflow, out} !== exp) begin n_failed++; $display("FAIL round_%0d: got %h expected %h", i, {overflow, out}, exp); end
            if (i == 0) begin
                n_compared++;
                if ({t_out_valid, t_overflow, t_out} !== {2'b10, 16'h00AA}) begin
                    n_failed++;
                    $display("FAIL truncate: got v=%b o=%b %h expected v=1 o=0 00aa", t_out_valid, t_overflow, t_out);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow();
        bit ok, rdy;
        int lat;
        logic [16:0] exp;
        logic [15:0] va[3] = '{16'h7F00, 16'h8000, 16'h8000};
        logic [15:0] vb[3] = '{16'h0080, 16'h0080, 16'h0100};
        logic [15:0] vr[3] = '{16'h7FFF, 16'h8000, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            drive_op(va[i], vb[i], {1'b1, vr[i]}, ok);
            wait_result(lat, rdy);
            exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
            n_compared++;
            if (!ok || {overflow, out} !== exp) begin n_failed++; $display("FAIL overflow_%0d: got %h expected %h", i, {overflow, out}, exp); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_div_by_zero();
        bit ok, rdy;
        int lat;
        logic [16:0] exp;
        drive_op(16'hFF00, 16'h0000, {1'b1, 16'h8000}, ok);
        wait_result(lat, rdy);
        n_compared++;
        if (!ok || lat != 1) begin n_failed++; $display("FAIL dbz_latency: got %0d expected 1", lat); end
        exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
        n_compared++;
        if ({overflow, out} !== exp) begin n_failed++; $display("FAIL dbz_neg: got %h expected %h", {overflow, out}, exp); end
        @(posedge clk); #1;
        drive_op(16'h0000, 16'h0000, {1'b1, 16'h7FFF}, ok);
        wait_result(lat, rdy);
        exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
        n_compared++;
        if (!ok || {overflow, out} !== exp) begin n_failed++; $display("FAIL dbz_zero: got %h expected %h", {overflow, out}, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        bit ok, rdy;
        int lat;
        int bad;
        logic [16:0] exp;
        out_ready = 1'b0;
        drive_op(16'h0100, 16'h0080, {1'b0, 16'h0200}, ok);
        wait_result(lat, rdy);
        exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
        n_compared++;
        if (!ok || {overflow, out} !== exp) begin n_failed++; $display("FAIL hold_result: got %h expected %h", {overflow, out}, exp); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_a = 16'h1234; in_b = 16'h0001;
            in_valid = (i == 3);
            @(posedge clk); #1;
            if ({out_valid, in_ready, overflow, out} !== {2'b10, exp}) bad++;
        end
        n_compared++;
        if (bad != 0) begin n_failed++; $display("FAIL hold_stable: got %0d bad cycles expected 0", bad); end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_compared++;
        if ({in_ready, out_valid} !== 2'b10) begin n_failed++; $display("FAIL release_idle: got %b expected 10", {in_ready, out_valid}); end
        drive_op(16'hFD00, 16'h0200, {1'b0, 16'hFE80}, ok);
        wait_result(lat, rdy);
        n_compared++;
        if (!ok || lat != 26) begin n_failed++; $display("FAIL b2b_latency: got %0d expected 26", lat); end
        exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
        n_compared++;
        if ({overflow, out} !== exp) begin n_failed++; $display("FAIL b2b_result: got %h expected %h", {overflow, out}, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        bit ok, rdy;
        int lat;
        logic [16:0] exp;
        drive_op(16'h7000, 16'h0300, model(16'h7000, 16'h0300), ok);
        repeat (12) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_compared++;
        if ({out_valid, in_ready, overflow, out} !== {3'b010, 16'h0000}) begin
            n_failed++;
            $display("FAIL mid_reset: got v=%b r=%b o=%b %h expected v=0 r=1 o=0 0000", out_valid, in_ready, overflow, out);
        end
        if (sb.size() != 0) void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        drive_op(16'h0100, 16'h0100, {1'b0, 16'h0100}, ok);
        wait_result(lat, rdy);
        n_compared++;
        if (!ok || lat != 26) begin n_failed++; $display("FAIL post_reset_latency: got %0d expected 26", lat); end
        exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
        n_compared++;
        if ({overflow, out} !== exp) begin n_failed++; $display("FAIL post_reset_result: got %h expected %h", {overflow, out}, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        bit ok, rdy;
        int lat;
        logic [16:0] exp;
        logic [15:0] a, b;
        for (int i = 0; i < 12; i++) begin
            a = 16'($urandom);
            b = (i % 4 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
            drive_op(a, b, model(a, b), ok);
            wait_result(lat, rdy);
            exp = (sb.size() != 0) ? sb.pop_front() : 17'hx;
            n_compared++;
            if (!ok || !out_valid || {overflow, out} !== exp) begin
                n_failed++;
                $display("FAIL random_%0d a=%h b=%h: got %h expected %h", i, a, b, {overflow, out}, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_div_by_zero();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
